// File: rtl/divider_32bit_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : divider_32bit_seq
//  Description : Iterative IEEE-754 single-precision divider, o_res = i_a / i_b.
//                Radix-2 restoring mantissa division, ITER_PER_CYCLE quotient
//                bits per clock. Special operands resolve in one cycle.
//                Denormal inputs are flushed to zero; rounding is truncation.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1   clock, rising edge
//    rst          in   1   reset, asynchronous, active-high
//    i_a          in   32  dividend, FP32
//    i_b          in   32  divisor, FP32
//    i_vld        in   1   operands valid, accepted when o_rdy=1
//    o_rdy        out  1   idle, can accept new operands
//    o_res        out  32  quotient, FP32, held until the next result
//    o_res_vld    out  1   one-cycle pulse, o_res updated this cycle
//    overflow     out  1   NaN, Inf or exponent overflow result
//    div_by_zero  out  1   finite nonzero divided by zero
// ============================================================================
module divider_32bit_seq #(
    parameter int ITER_PER_CYCLE = 1    // legal values: 1, 5, 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_vld,
    output logic        o_rdy,
    output logic [31:0] o_res,
    output logic        o_res_vld,
    output logic        overflow,
    output logic        div_by_zero
);

    localparam int          N_CYCLES = 25 / ITER_PER_CYCLE;
    localparam logic [4:0]  LAST_CNT = 5'(N_CYCLES - 1);
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // ------------------------------------------------------------------
    // Operand decode and special-case classification
    // ------------------------------------------------------------------
    logic        res_sign_in;
    logic [7:0]  a_exp;
    logic [7:0]  b_exp;
    logic [22:0] a_frac;
    logic [22:0] b_frac;
    logic        a_zero;
    logic        b_zero;
    logic        a_inf;
    logic        b_inf;
    logic        a_nan;
    logic        b_nan;

    assign res_sign_in = i_a[31] ^ i_b[31];
    assign a_exp       = i_a[30:23];
    assign b_exp       = i_b[30:23];
    assign a_frac      = i_a[22:0];
    assign b_frac      = i_b[22:0];

    // Denormals have exp==0 and are treated as zero regardless of fraction.
    assign a_zero = (a_exp == 8'h00);
    assign b_zero = (b_exp == 8'h00);
    assign a_inf  = (a_exp == 8'hFF) && (a_frac == 23'd0);
    assign b_inf  = (b_exp == 8'hFF) && (b_frac == 23'd0);
    assign a_nan  = (a_exp == 8'hFF) && (a_frac != 23'd0);
    assign b_nan  = (b_exp == 8'hFF) && (b_frac != 23'd0);

    logic        in_special;
    logic [31:0] in_special_res;
    logic        in_special_ovf;
    logic        in_special_dbz;

    // Priority order matters: e.g. Inf/0 is Inf (overflow), not div-by-zero.
    always_comb begin
        in_special     = 1'b1;
        in_special_res = 32'd0;
        in_special_ovf = 1'b0;
        in_special_dbz = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            in_special_res = QNAN;
            in_special_ovf = 1'b1;
        end else if (a_inf) begin
            in_special_res = {res_sign_in, 8'hFF, 23'd0};
            in_special_ovf = 1'b1;
        end else if (b_inf || a_zero) begin
            in_special_res = {res_sign_in, 31'd0};
        end else if (b_zero) begin
            in_special_res = {res_sign_in, 8'hFF, 23'd0};
            in_special_dbz = 1'b1;
        end else begin
            in_special = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic       accept;
    logic [4:0] cnt;

    assign o_rdy  = (state == IDLE);
    assign accept = i_vld && o_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_vld) begin
                    state_nxt = in_special ? NORM : CALC;
                end
            end
            CALC: begin
                if (cnt == LAST_CNT) begin
                    state_nxt = NORM;
                end
            end
            NORM: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture and iterative mantissa division
    // ------------------------------------------------------------------
    logic        res_sign;
    logic [7:0]  exp_a_q;
    logic [7:0]  exp_b_q;
    logic [23:0] mb;
    logic [25:0] rem;
    logic [24:0] quo;
    logic        is_special;
    logic [31:0] spec_res;
    logic        spec_ovf;
    logic        spec_dbz;

    logic [25:0] rem_nxt;
    logic [24:0] quo_nxt;

    // ITER_PER_CYCLE restoring steps chained combinationally per clock.
    always_comb begin
        rem_nxt = rem;
        quo_nxt = quo;
        for (int i = 0; i < ITER_PER_CYCLE; i++) begin
            if (rem_nxt >= {2'b00, mb}) begin
                rem_nxt = rem_nxt - {2'b00, mb};
                quo_nxt = {quo_nxt[23:0], 1'b1};
            end else begin
                quo_nxt = {quo_nxt[23:0], 1'b0};
            end
            rem_nxt = rem_nxt << 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_sign   <= 1'b0;
            exp_a_q    <= 8'd0;
            exp_b_q    <= 8'd0;
            mb         <= 24'd0;
            rem        <= 26'd0;
            quo        <= 25'd0;
            cnt        <= 5'd0;
            is_special <= 1'b0;
            spec_res   <= 32'd0;
            spec_ovf   <= 1'b0;
            spec_dbz   <= 1'b0;
        end else if (accept) begin
            res_sign   <= res_sign_in;
            exp_a_q    <= a_exp;
            exp_b_q    <= b_exp;
            mb         <= {1'b1, b_frac};
            rem        <= {2'b00, 1'b1, a_frac};
            quo        <= 25'd0;
            cnt        <= 5'd0;
            is_special <= in_special;
            spec_res   <= in_special_res;
            spec_ovf   <= in_special_ovf;
            spec_dbz   <= in_special_dbz;
        end else if (state == CALC) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 5'd1;
        end
    end

    // ------------------------------------------------------------------
    // Normalisation and exponent range handling
    // ------------------------------------------------------------------
    logic signed [9:0] exp_diff;
    logic signed [9:0] e_norm;
    logic [22:0]       mant;
    logic [31:0]       norm_res;
    logic              norm_ovf;

    // quo lies in [2^23, 2^25): a set top bit means the mantissa ratio >= 1.
    always_comb begin
        exp_diff = $signed({2'b00, exp_a_q}) - $signed({2'b00, exp_b_q});
        if (quo[24]) begin
            mant   = quo[23:1];
            e_norm = exp_diff + 10'sd127;
        end else begin
            mant   = quo[22:0];
            e_norm = exp_diff + 10'sd126;
        end
        norm_ovf = 1'b0;
        if (e_norm >= 10'sd255) begin
            norm_res = {res_sign, 8'hFF, 23'd0};
            norm_ovf = 1'b1;
        end else if (e_norm <= 10'sd0) begin
            norm_res = {res_sign, 31'd0};
        end else begin
            norm_res = {res_sign, e_norm[7:0], mant};
        end
    end

    // ------------------------------------------------------------------
    // Output registers: updated only in NORM, held otherwise
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_res       <= 32'd0;
            o_res_vld   <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            o_res_vld <= 1'b0;
            if (state == NORM) begin
                o_res_vld   <= 1'b1;
                o_res       <= is_special ? spec_res : norm_res;
                overflow    <= is_special ? spec_ovf : norm_ovf;
                div_by_zero <= is_special ? spec_dbz : 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_divider_32bit_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_divider_32bit_seq
//  Description : Self-checking bench for divider_32bit_seq. Two instances,
//                ITER_PER_CYCLE=1 and ITER_PER_CYCLE=5, exercised with
//                directed and randomized operands against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_32bit_seq;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        dbz;
        logic        spec;
    } exp_t;

    localparam int LN [2] = '{26, 6};

    localparam logic [31:0] DA [8] = '{32'h40C00000, 32'h3F800000, 32'hC0000000, 32'h3F800000,
                                       32'h80000000, 32'h00000001, 32'h7F000000, 32'h00800000};
    localparam logic [31:0] DB [8] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h00000000,
                                       32'h80000000, 32'h3F800000, 32'h3F000000, 32'h4F800000};
    localparam logic [31:0] DR [8] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0000000, 32'h7F800000,
                                       32'h7FC00000, 32'h00000000, 32'h7F800000, 32'h00000000};
    localparam bit DOVF [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam bit DDBZ [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam bit DSPC [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    logic        clk;
    logic        rst;
    logic [31:0] a_in    [2];
    logic [31:0] b_in    [2];
    logic        vld_in  [2];
    logic        rdy     [2];
    logic [31:0] res     [2];
    logic        res_vld [2];
    logic        ovf     [2];
    logic        dbz     [2];

    int n_assert = 0;
    int n_fail   = 0;

    divider_32bit_seq #(.ITER_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_a(a_in[0]), .i_b(b_in[0]), .i_vld(vld_in[0]),
        .o_rdy(rdy[0]), .o_res(res[0]), .o_res_vld(res_vld[0]),
        .overflow(ovf[0]), .div_by_zero(dbz[0])
    );

    divider_32bit_seq #(.ITER_PER_CYCLE(5)) u_dut5 (
        .clk(clk), .rst(rst), .i_a(a_in[1]), .i_b(b_in[1]), .i_vld(vld_in[1]),
        .o_rdy(rdy[1]), .o_res(res[1]), .o_res_vld(res_vld[1]),
        .overflow(ovf[1]), .div_by_zero(dbz[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer quotient of the mantissas, normalised into
    // [2^24, 2^25), then truncated to 23 fraction bits.
    function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b);
        exp_t            r;
        logic            s;
        int              ea;
        int              eb;
        int              e;
        bit              az, bz, ainf, binf, anan, bnan;
        longint unsigned q;
        ea   = int'(a[30:23]);
        eb   = int'(b[30:23]);
        az   = (ea == 0);
        bz   = (eb == 0);
        ainf = (ea == 255) && (a[22:0] == 23'd0);
        binf = (eb == 255) && (b[22:0] == 23'd0);
        anan = (ea == 255) && (a[22:0] != 23'd0);
        bnan = (eb == 255) && (b[22:0] != 23'd0);
        s    = a[31] ^ b[31];
        r.ovf  = 1'b0;
        r.dbz  = 1'b0;
        r.spec = 1'b1;
        r.res  = 32'd0;
        if (anan || bnan || (az && bz) || (ainf && binf)) begin
            r.res = 32'h7FC00000;
            r.ovf = 1'b1;
        end else if (ainf) begin
            r.res = {s, 8'hFF, 23'd0};
            r.ovf = 1'b1;
        end else if (binf || az) begin
            r.res = {s, 31'd0};
        end else if (bz) begin
            r.res = {s, 8'hFF, 23'd0};
            r.dbz = 1'b1;
        end else begin
            r.spec = 1'b0;
            q = (longint'({1'b1, a[22:0]}) << 24) / longint'({1'b1, b[22:0]});
            e = ea - eb + 127;
            if (q < 64'd16777216) begin
                q = q << 1;
                e = e - 1;
            end
            if (e >= 255) begin
                r.res = {s, 8'hFF, 23'd0};
                r.ovf = 1'b1;
            end else if (e <= 0) begin
                r.res = {s, 31'd0};
            end else begin
                r.res = {s, 8'(e), 23'(q >> 1)};
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic        s;
        logic [22:0] f;
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom);
        case ($urandom_range(0, 11))
            0:       return {s, 31'd0};
            1:       return {s, 8'hFF, 23'd0};
            2:       return {s, 8'hFF, f | 23'd1};
            3:       return {s, 8'h00, f};
            4, 5:    return {s, 8'($urandom_range(1, 254)), f};
            default: return {s, 8'($urandom_range(100, 154)), f};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Entered #1 after the accept edge; counts edges until o_res_vld.
    task automatic wait_result(input int d, input exp_t ev, input int exp_lat, input string tag);
        int lat;
        lat = 1;
        @(posedge clk); #1;
        while (!res_vld[d] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, res[d], ev.res);
        chk({tag, "_ovf"}, {31'd0, ovf[d]}, {31'd0, ev.ovf});
        chk({tag, "_dbz"}, {31'd0, dbz[d]}, {31'd0, ev.dbz});
        chk({tag, "_rdy"}, {31'd0, rdy[d]}, 32'd1);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {31'd0, res_vld[d]}, 32'd0);
        chk({tag, "_hold"}, {ovf[d], dbz[d], res[d][29:0]}, {ev.ovf, ev.dbz, ev.res[29:0]});
    endtask

    task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                          input exp_t ev, input string tag);
        @(negedge clk);
        chk({tag, "_idle"}, {31'd0, rdy[d]}, 32'd1);
        a_in[d]   = a;
        b_in[d]   = b;
        vld_in[d] = 1'b1;
        @(posedge clk); #1;
        vld_in[d] = 1'b0;
        wait_result(d, ev, ev.spec ? 1 : LN[d], tag);
    endtask

    initial begin
        exp_t ev;
        exp_t ev2;
        int   lowcnt;
        int   cyc;
        bit   seen;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            a_in[d]   = 32'd0;
            b_in[d]   = 32'd0;
            vld_in[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rst_state", d),
                {rdy[d], res_vld[d], ovf[d], dbz[d], res[d][27:0]}, 32'h8000_0000);
            chk($sformatf("d%0d_rst_res", d), res[d], 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed operands with hand-derived results
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                ev.res  = DR[i];
                ev.ovf  = DOVF[i];
                ev.dbz  = DDBZ[i];
                ev.spec = DSPC[i];
                run_op(d, DA[i], DB[i], ev, $sformatf("d%0d_dir%0d", d, i));
            end
        end

        // i_vld held high with junk operands while busy
        for (int d = 0; d < 2; d++) begin
            ev  = '{res: 32'h40400000, ovf: 1'b0, dbz: 1'b0, spec: 1'b0};
            ev2 = '{res: 32'h3EAAAAAA, ovf: 1'b0, dbz: 1'b0, spec: 1'b0};
            @(negedge clk);
            a_in[d]   = 32'h40C00000;
            b_in[d]   = 32'h40000000;
            vld_in[d] = 1'b1;
            @(posedge clk); #1;
            lowcnt = 0;
            cyc    = 0;
            while (!res_vld[d] && cyc < 100) begin
                if (!rdy[d]) lowcnt++;
                a_in[d] = $urandom;
                b_in[d] = $urandom;
                @(posedge clk); #1;
                cyc++;
            end
            chk($sformatf("d%0d_busy_lowcnt", d), 32'(lowcnt), 32'(LN[d]));
            chk($sformatf("d%0d_busy_res", d), res[d], ev.res);
            chk($sformatf("d%0d_busy_flags", d), {30'd0, ovf[d], dbz[d]}, 32'd0);
            a_in[d] = 32'h3F800000;
            b_in[d] = 32'h40400000;
            @(posedge clk); #1;
            chk($sformatf("d%0d_b2b_accept", d), {31'd0, rdy[d]}, 32'd0);
            vld_in[d] = 1'b0;
            wait_result(d, ev2, LN[d] - 1 + 1, $sformatf("d%0d_b2b", d));
        end

        // Reset in the middle of a calculation
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            a_in[d]   = 32'h40C00000;
            b_in[d]   = 32'h40000000;
            vld_in[d] = 1'b1;
            @(posedge clk); #1;
            vld_in[d] = 1'b0;
            repeat ((d == 0) ? 9 : 2) @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            chk($sformatf("d%0d_midrst_ctl", d),
                {28'd0, rdy[d], res_vld[d], ovf[d], dbz[d]}, 32'h8);
            chk($sformatf("d%0d_midrst_res", d), res[d], 32'd0);
            @(negedge clk);
            rst = 1'b0;
            seen = 1'b0;
            repeat (30) begin
                @(posedge clk); #1;
                if (res_vld[d]) seen = 1'b1;
            end
            chk($sformatf("d%0d_midrst_novld", d), {31'd0, seen}, 32'd0);
            ev = '{res: 32'h40400000, ovf: 1'b0, dbz: 1'b0, spec: 1'b0};
            run_op(d, 32'h40C00000, 32'h40000000, ev, $sformatf("d%0d_after_rst", d));
        end

        // Randomized operands against the reference model
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 20; k++) begin
                ra = rand_fp();
                rb = rand_fp();
                ev = ref_div(ra, rb);
                run_op(d, ra, rb, ev, $sformatf("d%0d_rnd%0d_%h_%h", d, k, ra, rb));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
